// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one multi-cycle FPU unit among
// NUM_REQ issue ports. Grants one request from IDLE, holds its operands
// registered on the unit for the whole operation, and routes the result back
// to the owner.
// Optional feature macro: FPU_ARB_RESULT_REG_EN registers u_rd and adds a DONE
// state, which adds one cycle of latency.
module fpu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_order,
    input  logic [NUM_REQ*DATA_W-1:0] req_rs1,
    input  logic [NUM_REQ*DATA_W-1:0] req_rs2,
    output logic [NUM_REQ-1:0]        req_accepted,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         rd,
    output logic                      busy,
    output logic                      u_order,
    output logic [DATA_W-1:0]         u_rs1,
    output logic [DATA_W-1:0]         u_rs2,
    input  logic                      u_accepted,
    input  logic                      u_done,
    input  logic [DATA_W-1:0]         u_rd
);

    localparam int unsigned N     = NUM_REQ;
    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, owner, grant_idx, rr_ptr_nxt;
    logic               grant_vld;
    logic               complete;
    int unsigned        scan;
`ifdef FPU_ARB_RESULT_REG_EN
    logic [DATA_W-1:0]  rd_q;
`endif

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan = (32'(rr_ptr) + k) % N;
            if (!grant_vld && req_order[PTR_W'(scan)]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(scan);
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        rr_ptr_nxt = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Next-state and handshake outputs; grants only ever come from IDLE.
    always_comb begin
        state_nxt    = state;
        req_accepted = '0;
        req_done     = '0;
        rd           = '0;
        complete     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_accepted[grant_idx] = 1'b1;
                    state_nxt               = ISSUE;
                end
            end
            ISSUE: begin
                // A single-cycle unit may accept and finish in the same cycle.
                if (u_accepted) begin
                    if (u_done) complete  = 1'b1;
                    else        state_nxt = BUSY;
                end
            end
            BUSY: begin
                complete = u_done;
            end
            DONE: begin
`ifdef FPU_ARB_RESULT_REG_EN
                req_done[owner] = 1'b1;
                rd              = rd_q;
`endif
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
`ifdef FPU_ARB_RESULT_REG_EN
            state_nxt = DONE;
`else
            req_done[owner] = 1'b1;
            rd              = u_rd;
            state_nxt       = IDLE;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the winner's operands, owner id and advance the pointer on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            owner  <= '0;
            u_rs1  <= '0;
            u_rs2  <= '0;
        end else if (|req_accepted) begin
            rr_ptr <= rr_ptr_nxt;
            owner  <= grant_idx;
            u_rs1  <= req_rs1[int'(grant_idx) * DATA_W +: DATA_W];
            u_rs2  <= req_rs2[int'(grant_idx) * DATA_W +: DATA_W];
        end
    end

`ifdef FPU_ARB_RESULT_REG_EN
    // Capture the unit result on completion; presented from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           rd_q <= '0;
        else if (complete) rd_q <= u_rd;
    end
`endif

    assign busy    = (state != IDLE);
    assign u_order = (state == ISSUE);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter (NUM_REQ=2, DATA_W=32). The FPU side is
// driven cycle by cycle from the stimulus; expected values are hand-derived.
module tb_fpu_share_arbiter;

    localparam int RL =
`ifdef FPU_ARB_RESULT_REG_EN
        1;
`else
        0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_order;
    logic [63:0] req_rs1, req_rs2;
    logic [1:0]  req_accepted, req_done;
    logic [31:0] rd, u_rs1, u_rs2, u_rd;
    logic        busy, u_order, u_accepted, u_done;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_share_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_order(req_order), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_accepted(req_accepted), .req_done(req_done), .rd(rd),
        .busy(busy), .u_order(u_order), .u_rs1(u_rs1), .u_rs2(u_rs2),
        .u_accepted(u_accepted), .u_done(u_done), .u_rd(u_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge of the cycle after req_accepted (unit sees ISSUE).
    // Returns #1 after the negedge of the first IDLE cycle after completion.
    task automatic serve(input logic [1:0] own, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int stall);
        for (int i = 0; i < stall; i++) begin
            u_accepted = 1'b0;
            #1;
            check("stall_order", u_order, 1);
            check("stall_rs1", u_rs1, a);
            check("stall_rs2", u_rs2, b);
            check("stall_done", req_done, 0);
            check("stall_acc", req_accepted, 0);
            step();
        end
        u_accepted = 1'b1;
        #1;
        check("issue_order", u_order, 1);
        check("issue_rs1", u_rs1, a);
        check("issue_rs2", u_rs2, b);
        check("issue_acc", req_accepted, 0);
        check("issue_done", req_done, 0);
        step();
        u_accepted = 1'b0;
        #1;
        check("busy_order", u_order, 0);
        check("busy_busy", busy, 1);
        check("busy_rs1", u_rs1, a);
        check("busy_rs2", u_rs2, b);
        check("busy_acc", req_accepted, 0);
        check("busy_done", req_done, 0);
        step();
        u_done = 1'b1;
        u_rd   = res;
        #1;
        check("udone_done", req_done, (RL != 0) ? 2'b00 : own);
        check("udone_rd", rd, (RL != 0) ? 32'h0 : res);
        check("udone_acc", req_accepted, 0);
        step();
        u_done = 1'b0;
        u_rd   = 32'hDEADBEEF;
        #1;
        check("after_done", req_done, (RL != 0) ? own : 2'b00);
        check("after_rd", rd, (RL != 0) ? res : 32'h0);
        check("after_busy", busy, (RL != 0) ? 1'b1 : 1'b0);
        if (RL != 0) begin
            step();
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req_order = 2'b11; req_rs1 = '0; req_rs2 = '0;
        u_accepted = 1'b0; u_done = 1'b0; u_rd = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_acc", req_accepted, 0);
        check("rst_done", req_done, 0);
        check("rst_rd", rd, 0);
        check("rst_order", u_order, 0);
        check("rst_rs1", u_rs1, 0);
        step();

        // Single op from requester 0: 1.0 + 2.0 = 3.0
        rst = 1'b0;
        req_order = 2'b01;
        req_rs1 = {32'h0, 32'h3F800000};
        req_rs2 = {32'h0, 32'h40000000};
        #1;
        check("single_acc", req_accepted, 2'b01);
        step();
        req_order = 2'b00;
        req_rs1 = {32'h55555555, 32'hAAAAAAAA};
        req_rs2 = {32'h66666666, 32'h99999999};
        serve(2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 0);
        check("single_idle_acc", req_accepted, 0);
        check("single_idle_busy", busy, 0);

        // Spurious u_done in IDLE
        step();
        u_done = 1'b1; u_rd = 32'h12345678;
        #1;
        check("spur_done", req_done, 0);
        check("spur_rd", rd, 0);
        step();
        u_done = 1'b0;
        #1;
        check("spur_busy", busy, 0);
        check("spur_order", u_order, 0);

        // Stalled unit on requester 1 (rr_ptr now 1)
        step();
        req_order = 2'b10;
        req_rs1 = {32'h11111111, 32'h0};
        req_rs2 = {32'h22222222, 32'h0};
        #1;
        check("stall_grant", req_accepted, 2'b10);
        step();
        req_order = 2'b00;
        req_rs1 = '1;
        req_rs2 = '1;
        serve(2'b10, 32'h11111111, 32'h22222222, 32'h33333333, 5);

        // Late request: requester 1 arrives while requester 0 is in flight
        step();
        req_order = 2'b01;
        req_rs1 = {32'hB0000001, 32'hA0000001};
        req_rs2 = {32'hB0000002, 32'hA0000002};
        #1;
        check("late_first", req_accepted, 2'b01);
        step();
        req_order = 2'b10;
        serve(2'b01, 32'hA0000001, 32'hA0000002, 32'hA0000003, 0);
        check("late_grant", req_accepted, 2'b10);
        step();
        req_order = 2'b00;
        serve(2'b10, 32'hB0000001, 32'hB0000002, 32'hB0000003, 0);

        // Contention: both held, rr_ptr now 0 -> 01,10,01,10
        step();
        req_order = 2'b11;
        req_rs1 = {32'hC1C1C1C1, 32'hC0C0C0C0};
        req_rs2 = {32'hD1D1D1D1, 32'hD0D0D0D0};
        #1;
        check("cont_g0", req_accepted, 2'b01);
        step();
        serve(2'b01, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'hE0000000, 0);
        check("cont_g1", req_accepted, 2'b10);
        step();
        serve(2'b10, 32'hC1C1C1C1, 32'hD1D1D1D1, 32'hE0000001, 0);
        check("cont_g2", req_accepted, 2'b01);
        step();
        serve(2'b01, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'hE0000002, 0);
        check("cont_g3", req_accepted, 2'b10);
        step();
        serve(2'b10, 32'hC1C1C1C1, 32'hD1D1D1D1, 32'hE0000003, 0);

        // Reset mid-BUSY after granting 0 (rr_ptr would be 1 without reset)
        check("pre_rst_g", req_accepted, 2'b01);
        step();
        req_order = 2'b00;
        u_accepted = 1'b1;
        step();
        u_accepted = 1'b0;
        #1;
        check("pre_rst_busy", busy, 1);
        step();
        rst = 1'b1; u_done = 1'b1; u_rd = 32'hFFFF0000;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", req_done, 0);
        check("mid_rst_rd", rd, 0);
        check("mid_rst_order", u_order, 0);
        check("mid_rst_rs1", u_rs1, 0);
        step();
        rst = 1'b0; u_done = 1'b0; u_rd = '0;
        req_order = 2'b11;
        #1;
        check("post_rst_g", req_accepted, 2'b01);
        step();
        req_order = 2'b00;
        serve(2'b01, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'h0F0F0F0F, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
